// File: rtl/msk_clyde_sbox_layer.sv
// Masked Clyde-128 S-box layer over a column-ordered d-share sharing.
// P columns enter a 2-stage pipeline of masked AND gadgets each RUN cycle.

module msk_clyde_sbox_and #(
    parameter int d = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [d-1:0]           a_i,
    input  logic [d-1:0]           b_i,
    input  logic [d-1:0]           l_i,
    input  logic [d*(d-1)/2-1:0]   r_i,
    output logic [d-1:0]           c_q
);
    // t[i][j] is the partial product a_i&b_j; each off-diagonal pair shares one fresh bit.
    logic [d-1:0][d-1:0] t;
    logic [d-1:0]        c_d;

    for (genvar i = 0; i < d; i++) begin : g_row
        for (genvar j = 0; j < d; j++) begin : g_col
            if (i == j) begin : g_diag
                assign t[i][j] = (a_i[i] & b_i[j]) ^ l_i[i];
            end else if (i < j) begin : g_up
                assign t[i][j] = (a_i[i] & b_i[j]) ^ r_i[i*(2*d-i-1)/2 + (j-i-1)];
            end else begin : g_lo
                assign t[i][j] = (a_i[i] & b_i[j]) ^ r_i[j*(2*d-j-1)/2 + (i-j-1)];
            end
        end
    end

    always_comb begin
        c_d = '0;
        for (int i = 0; i < d; i++) c_d[i] = ^t[i];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) c_q <= '0;
        else     c_q <= c_d;
    end
endmodule

module msk_clyde_sbox_lane #(
    parameter int d = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [4*d-1:0]           col_i,
    input  logic [d*(d-1)-1:0]       r1_i,
    input  logic [d*(d-1)-1:0]       r2_i,
    output logic [4*d-1:0]           col_o
);
    localparam int R = d*(d-1)/2;

    logic [d-1:0] x0, x1, x2, x3;
    logic [d-1:0] y0_q, y1_q, y2_q, y3_q;
    logic [d-1:0] x0_q, x0_d, x3_q, x3_d;
    logic [d-1:0] y0_s2_q, y0_s2_d, y1_s2_q, y1_s2_d;

    assign x0 = col_i[0*d +: d];
    assign x1 = col_i[1*d +: d];
    assign x2 = col_i[2*d +: d];
    assign x3 = col_i[3*d +: d];

    msk_clyde_sbox_and #(.d(d)) u_g_y1 (
        .clk(clk), .rst(rst), .a_i(x0), .b_i(x1), .l_i(x2), .r_i(r1_i[0 +: R]), .c_q(y1_q));
    msk_clyde_sbox_and #(.d(d)) u_g_y0 (
        .clk(clk), .rst(rst), .a_i(x3), .b_i(x0), .l_i(x1), .r_i(r1_i[R +: R]), .c_q(y0_q));
    msk_clyde_sbox_and #(.d(d)) u_g_y3 (
        .clk(clk), .rst(rst), .a_i(y1_q), .b_i(x3_q), .l_i(x0_q), .r_i(r2_i[0 +: R]), .c_q(y3_q));
    msk_clyde_sbox_and #(.d(d)) u_g_y2 (
        .clk(clk), .rst(rst), .a_i(y0_q), .b_i(y1_q), .l_i(x3_q), .r_i(r2_i[R +: R]), .c_q(y2_q));

    always_comb begin
        x0_d    = x0;
        x3_d    = x3;
        y0_s2_d = y0_q;
        y1_s2_d = y1_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x0_q    <= '0;
            x3_q    <= '0;
            y0_s2_q <= '0;
            y1_s2_q <= '0;
        end else begin
            x0_q    <= x0_d;
            x3_q    <= x3_d;
            y0_s2_q <= y0_s2_d;
            y1_s2_q <= y1_s2_d;
        end
    end

    assign col_o = {y3_q, y2_q, y1_s2_q, y0_s2_q};
endmodule

module msk_clyde_sbox_layer #(
    parameter int d     = 2,
    parameter int Nbits = 128,
    parameter int P     = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [Nbits*d-1:0]            cols_in,
    input  logic [P*4*d*(d-1)/2-1:0]      rnd,
    output logic                          busy,
    output logic                          done,
    output logic [Nbits*d-1:0]            cols_out
);
    localparam int NCH  = Nbits / (4*P);
    localparam int CW   = P*4*d;
    localparam int R    = d*(d-1)/2;
    localparam int HW   = P*2*R;
    localparam int CNTW = (NCH > 1) ? $clog2(NCH) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]           state_q, state_d;
    logic [CNTW-1:0]      cnt_q, cnt_d;
    logic [Nbits*d-1:0]   in_q, in_d;
    logic [1:0]           vld_q, vld_d;
    logic [CNTW-1:0]      idx1_q, idx1_d, idx2_q, idx2_d;
    logic [Nbits*d-1:0]   cols_out_q, cols_out_d;
    logic                 issue;

    logic [P-1:0][4*d-1:0] lane_in, lane_out;

    assign lane_in = in_q[cnt_q*CW +: CW];

    for (genvar p = 0; p < P; p++) begin : g_lane
        msk_clyde_sbox_lane #(.d(d)) u_lane (
            .clk   (clk),
            .rst   (rst),
            .col_i (lane_in[p]),
            .r1_i  (rnd[p*2*R +: 2*R]),
            .r2_i  (rnd[HW + p*2*R +: 2*R]),
            .col_o (lane_out[p])
        );
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        in_d    = in_q;
        issue   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    in_d    = cols_in;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                issue = 1'b1;
                if (cnt_q == CNTW'(NCH-1)) begin
                    cnt_d   = '0;
                    state_d = DRAIN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DRAIN: begin
                // Two cycles let the last chunk leave stage 2 before done.
                if (cnt_q == CNTW'(1)) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        vld_d  = {vld_q[0], issue};
        idx1_d = cnt_q;
        idx2_d = idx1_q;

        cols_out_d = cols_out_q;
        if (vld_q[1]) cols_out_d[idx2_q*CW +: CW] = lane_out;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            in_q       <= '0;
            vld_q      <= '0;
            idx1_q     <= '0;
            idx2_q     <= '0;
            cols_out_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            in_q       <= in_d;
            vld_q      <= vld_d;
            idx1_q     <= idx1_d;
            idx2_q     <= idx2_d;
            cols_out_q <= cols_out_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign cols_out = cols_out_q;
endmodule

// File: tb/tb_msk_clyde_sbox_layer.sv
// Randomized bench for msk_clyde_sbox_layer against an unshared nibble-level S-box model.

module tb_msk_clyde_sbox_layer;
    localparam int D    = 2;
    localparam int NB   = 128;
    localparam int P    = 4;
    localparam int NCOL = NB / 4;
    localparam int NCH  = NCOL / P;
    localparam int W    = NB * D;
    localparam int RW   = P * 4 * D * (D-1) / 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [W-1:0]  cols_in;
    logic [RW-1:0] rnd;
    logic          busy;
    logic          done;
    logic [W-1:0]  cols_out;

    int n_chk  = 0;
    int n_pass = 0;
    logic [W-1:0] last_cin;

    msk_clyde_sbox_layer #(.d(D), .Nbits(NB), .P(P)) dut (
        .clk(clk), .rst(rst), .start(start), .cols_in(cols_in), .rnd(rnd),
        .busy(busy), .done(done), .cols_out(cols_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", tag, obs, exp);
    endtask

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic y0, y1, y2, y3;
        y1 = (x[0] & x[1]) ^ x[2];
        y0 = (x[3] & x[0]) ^ x[1];
        y3 = (y1 & x[3]) ^ x[0];
        y2 = (y0 & y1) ^ x[3];
        return {y3, y2, y1, y0};
    endfunction

    function automatic logic [NB-1:0] model(input logic [NB-1:0] st);
        logic [NB-1:0] r;
        for (int c = 0; c < NCOL; c++) r[c*4 +: 4] = sbox(st[c*4 +: 4]);
        return r;
    endfunction

    function automatic logic [W-1:0] share_st(input logic [NB-1:0] st);
        logic [W-1:0] v;
        logic acc, b;
        v = '0;
        for (int c = 0; c < NCOL; c++)
            for (int j = 0; j < 4; j++) begin
                acc = 1'b0;
                for (int s = 0; s < D-1; s++) begin
                    b = 1'($urandom);
                    v[c*4*D + j*D + s] = b;
                    acc ^= b;
                end
                v[c*4*D + j*D + D-1] = st[c*4 + j] ^ acc;
            end
        return v;
    endfunction

    function automatic logic [NB-1:0] unshare(input logic [W-1:0] v);
        logic [NB-1:0] st;
        for (int c = 0; c < NCOL; c++)
            for (int j = 0; j < 4; j++)
                st[c*4 + j] = ^v[c*4*D + j*D +: D];
        return st;
    endfunction

    function automatic logic [W-1:0] rand_w();
        logic [W-1:0] v;
        for (int i = 0; i < W/32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [NB-1:0] rand_st();
        logic [NB-1:0] v;
        for (int i = 0; i < NB/32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic run(input logic [NB-1:0] st, input bit rvar, input bit poke);
        logic [W-1:0] cin;
        int n;
        cin = share_st(st);
        last_cin = cin;
        @(posedge clk); #1;
        cols_in = cin;
        start   = 1'b1;
        rnd     = RW'($urandom);
        @(posedge clk); #1;
        start   = 1'b0;
        cols_in = rand_w();
        chk("busy_on", W'(busy), W'(1));
        n = 0;
        while (!done && n < 40) begin
            if (rvar) rnd = RW'($urandom);
            start = poke && (n == 2);
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        chk("latency", W'(n), W'(NCH+2));
        chk("data", W'(unshare(cols_out)), W'(model(st)));
        start = poke;
        rnd   = RW'($urandom);
        @(posedge clk); #1;
        start = 1'b0;
        chk("done_pulse", W'(done), W'(0));
        chk("busy_off", W'(busy), W'(0));
        chk("hold", W'(unshare(cols_out)), W'(model(st)));
    endtask

    initial begin
        logic [NB-1:0] st;
        rst = 1'b1; start = 1'b0; cols_in = '0; rnd = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", W'(busy), W'(0));
        chk("rst_done", W'(done), W'(0));
        chk("rst_out", cols_out, '0);
        rst = 1'b0;

        run('0, 1'b1, 1'b0);

        st = {NB{1'b1}};
        run(st, 1'b1, 1'b0);
        chk("f_shares_differ", W'(cols_out != last_cin), W'(1));

        for (int c = 0; c < NCOL; c++) st[c*4 +: 4] = 4'(c % 16);
        run(st, 1'b1, 1'b0);
        run(st, 1'b0, 1'b0);

        run(rand_st(), 1'b1, 1'b1);

        // Reset partway through a run.
        @(posedge clk); #1;
        cols_in = share_st(rand_st());
        start   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", W'(busy), W'(0));
        chk("mid_rst_done", W'(done), W'(0));
        chk("mid_rst_out", cols_out, '0);
        @(posedge clk); #1;
        rst = 1'b0;
        run(rand_st(), 1'b1, 1'b0);

        for (int i = 0; i < 4; i++) run(rand_st(), 1'($urandom), 1'($urandom));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
